// File: rtl/arb_pkg.sv
// Shared constants, state type and round-robin search for the 8-way arbiter.
// The search rotates the request vector so the favoured index sits at bit 0, then priority-encodes.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set bit at or after (last+1) mod N_REQ, wrapping upward.
  // If req is zero the result is the start index; callers only use it when req is non-zero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0]   start;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    logic               found;
    start = last + IDX_W'(1);
    dbl   = {req, req} >> start;
    rot   = dbl[N_REQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && rot[j]) begin
        off   = IDX_W'(j);
        found = 1'b1;
      end
    end
    return start + off;
  endfunction

endpackage

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder with enable.
// Latency: combinational. Backpressure: none.
// Output is all zeros while enable is low.
module decoder_3to8 (
  input  logic [2:0] in,
  input  logic       enable,
  output logic [7:0] out
);

  always_comb begin
    out = 8'h00;
    if (enable) out[in] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with grant hold and hold-time watchdog.
// Latency: request to grant 1 cycle; one idle cycle between tenures.
// Backpressure: owner holds until rel, drops its req, or the watchdog revokes after MAX_HOLD cycles.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,   // release pulse; "release" is a reserved word
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant,
  output logic             timeout
);

  arb_state_t       state;
  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout     <= 1'b0;
      last_idx    <= IDX_W'(N_REQ - 1);
      hold_cnt    <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (req != '0) begin
            grant_idx   <= rr_pick(req, last_idx);
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          // Release and owner-drop are one event; the watchdog only fires if neither occurred.
          if (rel || !req[grant_idx]) begin
            grant_valid <= 1'b0;
            last_idx    <= grant_idx;
            state       <= IDLE;
          end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            grant_valid <= 1'b0;
            last_idx    <= grant_idx;
            timeout     <= 1'b1;
            state       <= IDLE;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  decoder_3to8 u_dec (
    .in     (grant_idx),
    .enable (grant_valid),
    .out    (grant)
  );

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-requester round-robin arbiter with grant hold and hold-time watchdog. It shares a single downstream resource among eight requesters. It registers the winning 3-bit index and an enable, then expands them to a one-hot grant vector through an embedded 3-to-8 decoder. It is the sequencing front end for any shared port whose select lines are driven by a `decoder_3to8` instance.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one requester may hold the grant. Legal range is 2..256.
- `CNT_W`, default 8: width of the hold counter. Must satisfy 2^CNT_W ≥ MAX_HOLD.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 8: request vector, one bit per requester. Level-sensitive.
- `release` in 1: one-cycle pulse from the current owner ending its tenure.
- `grant_valid` out 1: a grant is active.
- `grant_idx` out 3: index of the current owner. Meaningful only while `grant_valid`=1.
- `grant` out 8: one-hot grant, equal to decode(`grant_idx`) gated by `grant_valid`. All zeros when idle.
- `timeout` out 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- **States:** IDLE, GRANT. The state is held in a register.
- **IDLE:**
  - If `req`≠0, select the first set bit at or after (`last_idx`+1) mod 8, searching upward with wrap from 7 to 0.
  - Register that bit as `grant_idx` and set `grant_valid`=1. Clear the hold counter. Move to GRANT.
  - If `req`=0, stay in IDLE.
- **GRANT:** leave the state at the first of these conditions, in this priority order:
  1. `release`=1: end the grant normally.
  2. `req[grant_idx]`=0: owner dropped its request. Treated as a release.
  3. Hold counter = MAX_HOLD−1: forced revoke. Assert `timeout` for one cycle, coinciding with the grant dropping.
- **Leaving GRANT:**
  - Go to IDLE and deassert `grant_valid`.
  - Load `last_idx` ← `grant_idx`, so the revoked or releasing owner becomes lowest priority next round.
- **Hold counter:** increments each cycle spent in GRANT. It saturates, never wraps, and clears on entry to GRANT.
- **Ignored inputs:** `release` while in IDLE has no effect. `release` asserted together with the owner dropping `req` is a single release event.
- **Requester changes:** requesters may assert or drop `req` at any time. Only the owner's bit affects GRANT. Non-owner changes are sampled at the next IDLE arbitration.
- **Fairness:** with all eight bits held high and owners releasing, grants rotate 0,1,…,7,0,… No requester waits more than 7 tenures.

## Timing
- **Reset values:** `grant_valid`=0, `grant_idx`=0, `grant`=8'h00, `timeout`=0. State = IDLE. `last_idx`=7, so the first arbitration favours index 0. Hold counter = 0.
- **Reset mid-grant:** `rst` in any cycle forces all reset values on that edge. The grant is lost with no `timeout` pulse.
- **Request-to-grant latency:** `req` sampled high in IDLE at edge N gives `grant_valid`/`grant` high after edge N. That is 1 cycle.
- **End of grant:**
  - `release` sampled at edge M clears the grant after edge M.
  - IDLE arbitrates at edge M+1, so the next grant is visible after edge M+1.
  - Minimum idle gap between tenures is exactly one cycle, including re-grant to the same index when it is the only requester.
- **Maximum tenure:**
  - With no release, the grant is visible for exactly MAX_HOLD cycles.
  - `timeout` is high during the first IDLE cycle after revocation, i.e. the cycle `grant_valid` first reads 0.
- **Combinational path:** `grant` is combinational from registered `grant_idx`/`grant_valid` only. There is no path from input to output.

## Structure
- **Shared package `arb_pkg`:**
  - Constants `N_REQ`=8 and `IDX_W`=3.
  - State enum type `arb_state_t` {IDLE, GRANT}.
- **Sub-module:** instantiate the existing `decoder_3to8`, with `in`=`grant_idx`, `enable`=`grant_valid`, `out`=`grant`. There is no other sub-module.
- **Next-index search:** a rotate-then-priority-encode function, placed locally or in `arb_pkg`.

## Test plan
- **Post-reset single request:** `req`=8'h01 → after 1 cycle `grant`=8'h01, `grant_idx`=0. Hold `req` and pulse `release` after 3 cycles → one idle cycle, then `grant`=8'h01 again.
- **Full contention rotation:** `req`=8'hFF, owner releases after 2 cycles each time → `grant_idx` sequence 0,1,2,…,7,0, with one idle cycle between tenures.
- **Wrap and skip:** after owner 5 releases with `req`=8'b0000_1001 → next grant idx 0, then idx 3.
- **Watchdog:** MAX_HOLD=4, `req`=8'h04, never release → `grant`=8'h04 for exactly 4 cycles. Then `timeout`=1 for 1 cycle with `grant`=0, then re-grant idx 2.
- **Owner drops req:** owner idx 6 drops `req[6]` while `req[1]`=1 → next cycle idle with no `timeout`, then idx 1 granted.
- **Reset mid-grant:** assert `rst` while idx 3 is granted → all outputs 0 after the edge. After deassert with `req`=8'hFF → first grant idx 0.
